// File: rtl/eu_param.sv
// eu_param: parametrised execution unit.
// Latches a decoded instruction and mode from the control unit. Operands are
// fetched through the BIU request/acknowledge handshake. An internal ALU runs
// with a configurable latency, and the result is written back over the BIU.
// The unit keeps an accumulator and {C,Z,N} status flags. An illegal mode is
// answered with err alongside done.
// All outputs come straight from flops. Each output flop is loaded from a
// decode of the next state, so it changes in step with the state register.

module eu_param #(
    parameter int DW      = 16,
    parameter int IRW     = 32,
    parameter int OP_LSB  = 16,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [IRW-1:0] ir,
    output logic           biu_req,
    output logic [1:0]     biu_sel,
    input  logic           biu_ack,
    input  logic [DW-1:0]  bus_in,
    output logic [DW-1:0]  bus_out,
    output logic           bus_oe,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2:0]     flags
);

    // Shift amount width and EXEC down-counter width.
    localparam int SW = $clog2(DW);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

    // Operating modes.
    localparam logic [1:0] MODE_ARITH_I = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ACCUM   = 2'b10;

    // BIU transfer selectors.
    localparam logic [1:0] SEL_RD_A = 2'b00;
    localparam logic [1:0] SEL_RD_B = 2'b01;
    localparam logic [1:0] SEL_WR   = 2'b10;

    // ALU opcodes.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_RD_A   = 3'd2,
        S_RD_B   = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // ALU: returns {carry, result}. The carry is the carry-out for ADD, the
    // borrow for SUB, and the last bit shifted out for shifts. Shifts are done
    // on a DW+1 wide copy with an extra zero bit, so the shifted-out bit lands
    // in that extra position. That bit stays zero when the shift amount is zero.
    function automatic logic [DW:0] alu_fn(input logic [2:0]    op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [SW-1:0] sh;
        logic [DW:0]   shl_w;
        logic [DW:0]   shr_w;
        logic [DW:0]   res;
        sh    = b[SW-1:0];
        shl_w = {1'b0, a} << sh;
        shr_w = {a, 1'b0} >> sh;
        case (op)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_SHL:  res = shl_w;
            OP_SHR:  res = {shr_w[0], shr_w[DW:1]};
            OP_PASS: res = {1'b0, b};
            default: res = {1'b0, b};
        endcase
        return res;
    endfunction

    // Packs a {carry, result} word into {C,Z,N}.
    function automatic logic [2:0] flags_fn(input logic [DW:0] cr);
        return {cr[DW], (cr[DW-1:0] == {DW{1'b0}}), cr[DW-1]};
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [1:0]      mode_r;
    logic [2:0]      op_r;
    logic [DW-1:0]   imm_r;
    logic [DW-1:0]   op_a_r;
    logic [DW-1:0]   op_b_r;
    logic [DW-1:0]   acc_r;
    logic [DW-1:0]   result_r;
    logic [2:0]      flags_r;
    logic [CW-1:0]   cnt_r;
    logic            req_r;
    logic [1:0]      sel_r;
    logic            oe_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;

    logic            xfer_s;
    logic [DW:0]     alu_s;
    logic            req_nx_s;
    logic [1:0]      sel_nx_s;
    logic            oe_nx_s;
    logic            busy_nx_s;
    logic            done_nx_s;
    logic            err_nx_s;

    // A transfer completes only when an ack meets an outstanding request.
    assign xfer_s = req_r & biu_ack;
    assign alu_s  = alu_fn(op_r, op_a_r, op_b_r);

    // Next-state logic for the sequencing FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_DECODE: begin
                case (mode_r)
                    MODE_ARITH_I: next_state_s = S_RD_A;
                    MODE_ARITH:   next_state_s = S_RD_A;
                    MODE_ACCUM:   next_state_s = S_RD_B;
                    default:      next_state_s = S_DONE;
                endcase
            end
            S_RD_A: begin
                if (xfer_s) begin
                    if (mode_r == MODE_ARITH) begin
                        next_state_s = S_RD_B;
                    end else begin
                        next_state_s = S_EXEC;
                    end
                end else begin
                    next_state_s = S_RD_A;
                end
            end
            S_RD_B: begin
                if (xfer_s) begin
                    next_state_s = S_EXEC;
                end else begin
                    next_state_s = S_RD_B;
                end
            end
            S_EXEC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_WB: begin
                if (xfer_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Decode the state being entered into output values for the output flops.
    always_comb begin
        req_nx_s  = 1'b0;
        sel_nx_s  = SEL_RD_A;
        oe_nx_s   = 1'b0;
        busy_nx_s = (next_state_s != S_IDLE);
        done_nx_s = 1'b0;
        err_nx_s  = 1'b0;
        case (next_state_s)
            S_RD_A: begin
                req_nx_s = 1'b1;
                sel_nx_s = SEL_RD_A;
            end
            S_RD_B: begin
                req_nx_s = 1'b1;
                sel_nx_s = SEL_RD_B;
            end
            S_WB: begin
                req_nx_s = 1'b1;
                sel_nx_s = SEL_WR;
                oe_nx_s  = 1'b1;
            end
            S_DONE: begin
                done_nx_s = 1'b1;
                err_nx_s  = (mode_r == 2'b11);
            end
            default: begin
                req_nx_s = 1'b0;
            end
        endcase
    end

    // Output flops. The async reset drops req and oe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r  <= 1'b0;
            sel_r  <= 2'b00;
            oe_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            req_r  <= req_nx_s;
            sel_r  <= sel_nx_s;
            oe_r   <= oe_nx_s;
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
            err_r  <= err_nx_s;
        end
    end

    // Instruction latch, operand capture, ALU result/flags and accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= 2'b00;
            op_r     <= 3'b000;
            imm_r    <= {DW{1'b0}};
            op_a_r   <= {DW{1'b0}};
            op_b_r   <= {DW{1'b0}};
            acc_r    <= {DW{1'b0}};
            result_r <= {DW{1'b0}};
            flags_r  <= 3'b000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        op_r   <= ir[OP_LSB+2:OP_LSB];
                        imm_r  <= ir[DW-1:0];
                    end
                end
                S_RD_A: begin
                    if (xfer_s) begin
                        op_a_r <= bus_in;
                        if (mode_r == MODE_ARITH_I) begin
                            op_b_r <= imm_r;
                        end
                    end
                end
                S_RD_B: begin
                    if (xfer_s) begin
                        op_b_r <= bus_in;
                        if (mode_r == MODE_ACCUM) begin
                            op_a_r <= acc_r;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        result_r <= alu_s[DW-1:0];
                        flags_r  <= flags_fn(alu_s);
                    end
                end
                S_WB: begin
                    if (xfer_s) begin
                        acc_r <= result_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // EXEC latency counter: reloaded on the way into EXEC, counts down inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                S_DECODE, S_RD_A, S_RD_B: cnt_r <= CNT_LOAD;
                S_EXEC: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign biu_req = req_r;
    assign biu_sel = sel_r;
    assign bus_oe  = oe_r;
    assign bus_out = result_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign flags   = flags_r;

endmodule

// File: tb/tb_eu_param.sv
// Testbench for eu_param. The bench acts as the BIU with programmable wait
// states. It checks directed cases and randomized instructions against a
// behavioural model of the unit.
`timescale 1ns/1ps

module tb_eu_param;
    localparam int DW     = 16;
    localparam int IRW    = 32;
    localparam int OP_LSB = 16;
    localparam int LAT    = 3;
    localparam int M      = 1 << DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [IRW-1:0] ir = '0;
    logic           biu_req;
    logic [1:0]     biu_sel;
    logic           biu_ack = 1'b0;
    logic [DW-1:0]  bus_in = '0;
    logic [DW-1:0]  bus_out;
    logic           bus_oe, busy, done, err;
    logic [2:0]     flags;

    int errors = 0;
    int checks = 0;

    // Model state and observations from the last operation.
    logic [DW-1:0] acc_m = '0;
    logic [2:0]    flags_m = 3'b000;
    int            o_lat, o_seq;
    logic [DW-1:0] o_wdata;
    logic          o_err, o_proto_bad, o_done2, o_busy2;

    always #5 clk = ~clk;

    eu_param #(.DW(DW), .IRW(IRW), .OP_LSB(OP_LSB), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ir(ir),
        .biu_req(biu_req), .biu_sel(biu_sel), .biu_ack(biu_ack),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .busy(busy), .done(done), .err(err), .flags(flags)
    );

    // Reference ALU computed with integer arithmetic; returns {C, result}.
    function automatic logic [DW:0] ref_alu(input int op, input int a, input int b);
        int r, c, sh;
        logic [DW:0] out;
        sh = b % DW;
        c  = 0;
        case (op)
            0: begin r = a + b; c = (r >= M) ? 1 : 0; r = r % M; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + M) % M; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << sh) % M; c = (sh == 0) ? 0 : ((a >> (DW - sh)) & 1); end
            6: begin r = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
            default: r = b;
        endcase
        out[DW-1:0] = r[DW-1:0];
        out[DW]     = c[0];
        return out;
    endfunction

    function automatic logic [IRW-1:0] mk_ir(input logic [2:0] op, input logic [DW-1:0] imm);
        logic [12:0] hi;
        hi = 13'($urandom);
        return {hi, op, imm};
    endfunction

    // Launches one instruction and plays the BIU. wa/wb/ww are the wait cycles
    // inserted before acking read-A, read-B and the write. With noise set, the
    // bench also changes mode/ir after acceptance, pulses start while the unit
    // is busy, and raises ack while no request is outstanding.
    task automatic run_op(input logic [1:0] m, input logic [IRW-1:0] instr,
                          input logic [DW-1:0] da, input logic [DW-1:0] db,
                          input int wa, input int wb, input int ww, input bit noise);
        int  wcnt;
        bit  need_new;
        o_lat = -1; o_seq = 0; o_wdata = '0; o_err = 1'b0; o_proto_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; ir = instr; biu_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise) begin
            mode = 2'($urandom);
            ir   = IRW'($urandom);
        end
        need_new = 1'b1;
        wcnt = 0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0; biu_ack = 1'b0; bus_in = DW'($urandom);
            if (done) begin
                o_lat = k; o_err = err;
                break;
            end
            if (!busy || err) o_proto_bad = 1'b1;
            if (bus_oe !== (biu_req && biu_sel == 2'b10)) o_proto_bad = 1'b1;
            if (biu_req) begin
                if (need_new) begin
                    need_new = 1'b0;
                    o_seq = o_seq * 4 + int'(biu_sel) + 1;
                    wcnt = (biu_sel == 2'b00) ? wa : (biu_sel == 2'b01) ? wb : ww;
                end
                if (wcnt == 0) begin
                    biu_ack = 1'b1; need_new = 1'b1;
                    if (biu_sel == 2'b00) bus_in = da;
                    else if (biu_sel == 2'b01) bus_in = db;
                    else o_wdata = bus_out;
                end else begin
                    wcnt--;
                end
            end else if (noise) begin
                biu_ack = 1'($urandom);
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                start = 1'b1; mode = 2'($urandom); ir = IRW'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0; biu_ack = 1'b0;
        o_done2 = done; o_busy2 = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({biu_req, biu_sel, bus_oe, busy, done, err, flags, bus_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b sel=%0b oe=%0b busy=%0b done=%0b err=%0b flags=%0b bus_out=%h, all required 0",
                     biu_req, biu_sel, bus_oe, busy, done, err, flags, bus_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_arith_i();
        run_op(2'b00, mk_ir(3'b000, 16'h0001), 16'h7FFF, 16'h0000, 0, 0, 0, 1'b0);
        checks++; if (o_lat !== 4 + LAT) begin errors++; $display("FAIL addi_latency: got %0d required %0d", o_lat, 4 + LAT); end
        checks++; if (o_wdata !== 16'h8000) begin errors++; $display("FAIL addi_result: got %h required 8000", o_wdata); end
        checks++; if (flags !== 3'b001) begin errors++; $display("FAIL addi_flags: got %b required 001", flags); end
        checks++; if (o_seq !== 7) begin errors++; $display("FAIL addi_sel_seq: got %0d required 7", o_seq); end
        checks++; if (o_done2 !== 1'b0 || o_busy2 !== 1'b0 || o_proto_bad) begin
            errors++; $display("FAIL addi_protocol: done2=%0b busy2=%0b bad=%0b required 0 0 0", o_done2, o_busy2, o_proto_bad);
        end
        acc_m = 16'h8000; flags_m = 3'b001;
    endtask

    task automatic test_arith();
        run_op(2'b01, mk_ir(3'b001, 16'h5A5A), 16'h0003, 16'h0005, 2, 2, 0, 1'b0);
        checks++; if (o_lat !== 5 + LAT + 4) begin errors++; $display("FAIL sub_latency: got %0d required %0d", o_lat, 9 + LAT); end
        checks++; if (o_wdata !== 16'hFFFE) begin errors++; $display("FAIL sub_result: got %h required fffe", o_wdata); end
        checks++; if (flags !== 3'b101) begin errors++; $display("FAIL sub_flags: got %b required 101", flags); end
        checks++; if (o_seq !== 27) begin errors++; $display("FAIL sub_sel_seq: got %0d required 27", o_seq); end
        acc_m = 16'hFFFE; flags_m = 3'b101;
    endtask

    task automatic test_accum();
        run_op(2'b10, mk_ir(3'b100, 16'h1234), 16'h1111, 16'hFFFE, 0, 0, 1, 1'b0);
        checks++; if (o_wdata !== 16'h0000) begin errors++; $display("FAIL accum_result: got %h required 0000", o_wdata); end
        checks++; if (flags !== 3'b010) begin errors++; $display("FAIL accum_flags: got %b required 010", flags); end
        checks++; if (o_seq !== 11) begin errors++; $display("FAIL accum_sel_seq: got %0d required 11 (read B only)", o_seq); end
        checks++; if (o_lat !== 5 + LAT) begin errors++; $display("FAIL accum_latency: got %0d required %0d", o_lat, 5 + LAT); end
        acc_m = 16'h0000; flags_m = 3'b010;
    endtask

    task automatic test_illegal();
        run_op(2'b11, mk_ir(3'b000, 16'h0001), 16'h0001, 16'h0001, 0, 0, 0, 1'b1);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d required 2", o_lat); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %0b required 1", o_err); end
        checks++; if (o_seq !== 0) begin errors++; $display("FAIL illegal_no_req: got seq %0d required 0", o_seq); end
        checks++; if (flags !== flags_m) begin errors++; $display("FAIL illegal_flags_hold: got %b required %b", flags, flags_m); end
        checks++; if (o_busy2 !== 1'b0) begin errors++; $display("FAIL illegal_busy_start_ignored: busy=%0b required 0", o_busy2); end
    endtask

    task automatic test_shift();
        run_op(2'b00, mk_ir(3'b101, 16'h0001), 16'h8001, 16'h0000, 0, 0, 0, 1'b0);
        checks++; if ({flags, o_wdata} !== {3'b100, 16'h0002}) begin
            errors++; $display("FAIL shl_by1: got flags=%b res=%h required 100 0002", flags, o_wdata);
        end
        run_op(2'b00, mk_ir(3'b110, 16'h0001), 16'h8001, 16'h0000, 0, 0, 0, 1'b0);
        checks++; if ({flags, o_wdata} !== {3'b100, 16'h4000}) begin
            errors++; $display("FAIL shr_by1: got flags=%b res=%h required 100 4000", flags, o_wdata);
        end
        run_op(2'b00, mk_ir(3'b101, 16'hFFF0), 16'hFFFF, 16'h0000, 0, 0, 0, 1'b0);
        checks++; if ({flags, o_wdata} !== {3'b001, 16'hFFFF}) begin
            errors++; $display("FAIL shl_by0: got flags=%b res=%h required 001 ffff", flags, o_wdata);
        end
        acc_m = 16'hFFFF; flags_m = 3'b001;
    endtask

    task automatic test_random();
        logic [1:0]    m;
        logic [2:0]    op;
        logic [DW-1:0] imm, da, db, a, b;
        logic [DW:0]   res;
        logic [2:0]    ef;
        int wa, wb, ww, elat, eseq;
        for (int n = 0; n < 60; n++) begin
            m  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            op = 3'($urandom);
            imm = DW'($urandom);
            da = ($urandom_range(0, 4) == 0) ? 16'hFFFF : DW'($urandom);
            db = ($urandom_range(0, 4) == 0) ? 16'h8000 : DW'($urandom);
            wa = $urandom_range(0, 2); wb = $urandom_range(0, 2); ww = $urandom_range(0, 2);
            run_op(m, {13'($urandom), op, imm}, da, db, wa, wb, ww, 1'b1);
            case (m)
                2'b00:   begin a = da;    b = imm; eseq = 7;  elat = 4 + LAT + wa + ww; end
                2'b01:   begin a = da;    b = db;  eseq = 27; elat = 5 + LAT + wa + wb + ww; end
                2'b10:   begin a = acc_m; b = db;  eseq = 11; elat = 4 + LAT + wb + ww; end
                default: begin a = '0;    b = '0;  eseq = 0;  elat = 2; end
            endcase
            res = ref_alu(int'(op), int'(a), int'(b));
            if (m != 2'b11) begin
                ef = {res[DW], res[DW-1:0] == '0, res[DW-1]};
                checks++; if (o_wdata !== res[DW-1:0]) begin
                    errors++; $display("FAIL rand_result[%0d]: mode=%0d op=%0d a=%h b=%h got %h required %h", n, m, op, a, b, o_wdata, res[DW-1:0]);
                end
                acc_m = res[DW-1:0]; flags_m = ef;
            end
            checks++; if (flags !== flags_m) begin errors++; $display("FAIL rand_flags[%0d]: mode=%0d op=%0d got %b required %b", n, m, op, flags, flags_m); end
            checks++; if (o_lat !== elat) begin errors++; $display("FAIL rand_latency[%0d]: mode=%0d got %0d required %0d", n, m, o_lat, elat); end
            checks++; if (o_seq !== eseq) begin errors++; $display("FAIL rand_sel_seq[%0d]: mode=%0d got %0d required %0d", n, m, o_seq, eseq); end
            checks++; if (o_err !== (m == 2'b11)) begin errors++; $display("FAIL rand_err[%0d]: got %0b required %0b", n, o_err, m == 2'b11); end
            checks++; if (o_proto_bad || o_done2 !== 1'b0 || o_busy2 !== 1'b0) begin
                errors++; $display("FAIL rand_protocol[%0d]: bad=%0b done2=%0b busy2=%0b required 0 0 0", n, o_proto_bad, o_done2, o_busy2);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'b00; ir = mk_ir(3'b101, 16'h0001);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            biu_ack = 1'b0;
            if (biu_req && biu_sel == 2'b10) begin
                rst_n = 1'b0;
                #1;
                hit = 1'b1;
                checks++; if ({biu_req, bus_oe, busy, flags} !== 6'b0) begin
                    errors++; $display("FAIL reset_in_wb: req=%0b oe=%0b busy=%0b flags=%b required all 0", biu_req, bus_oe, busy, flags);
                end
                break;
            end else if (biu_req) begin
                biu_ack = 1'b1; bus_in = 16'h8001;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL reset_wb_timeout: write-back never reached, got 0 required 1"); end
        biu_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = '0; flags_m = 3'b000;
        run_op(2'b10, mk_ir(3'b000, 16'h0000), 16'h0000, 16'h0005, 0, 0, 0, 1'b0);
        checks++; if (o_wdata !== 16'h0005) begin errors++; $display("FAIL acc_cleared: got %h required 0005", o_wdata); end
    endtask

    initial begin
        test_reset();
        test_arith_i();
        test_arith();
        test_accum();
        test_illegal();
        test_shift();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
